// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator request unit and ElevatorFSM.
package elevator_pkg;

  localparam int unsigned N_FLOORS_DEF = 4;
  localparam int unsigned FLOOR_W_DEF  = 2;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_e;

endpackage

// File: rtl/req_debounce.sv
// One request input: 2-FF synchroniser, optional debounce, rising-edge pulse.
// Optional debounce is enabled by defining REQ_DEBOUNCE_EN.
module req_debounce
`ifdef REQ_DEBOUNCE_EN
#(
  parameter int unsigned DEB_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c
);

  logic sync1_q;
  logic sync2_q;
  logic lvl;
  logic lvl_d_q;

  // Two-stage synchroniser for the asynchronous switch level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

`ifdef REQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             lvl_q;

  // Accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (sync2_q == lvl_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      cnt_q <= '0;
      lvl_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync2_q;
`endif

  // Previous accepted level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d_q <= 1'b0;
    end else begin
      lvl_d_q <= lvl;
    end
  end

  assign rise_c = lvl & ~lvl_d_q;

endmodule

// File: rtl/elevator_request_unit.sv
// Elevator request unit: conditions hall/cabin inputs, latches pending requests,
// clears them on service and picks the next target floor with SCAN ordering.
// Define REQ_DEBOUNCE_EN to insert a DEB_CYCLES debounce after each synchroniser.
module elevator_request_unit
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = N_FLOORS_DEF,
  parameter int unsigned FLOOR_W  = FLOOR_W_DEF
`ifdef REQ_DEBOUNCE_EN
  ,
  parameter int unsigned DEB_CYCLES = 16
`endif
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [N_FLOORS-1:0] hall_req_i,
  input  logic [N_FLOORS-1:0] cab_req_n_i,
  input  logic [FLOOR_W-1:0]  cur_floor_i,
  input  logic                svc_ack_i,
  output logic [N_FLOORS-1:0] pending_o,
  output logic                target_valid_o,
  output logic [FLOOR_W-1:0]  target_floor_o,
  output logic [1:0]          dir_o
);

  localparam int unsigned N_IN = 2 * N_FLOORS;

  logic [N_IN-1:0]     raw_lvl;
  logic [N_IN-1:0]     set_all_c;
  logic [N_FLOORS-1:0] set_c;
  logic [N_FLOORS-1:0] clr_c;
  logic [N_FLOORS-1:0] pending_q;

  int unsigned         cur_c;
  logic                cur_ok_c;

  logic                any_c;
  logic                at_c;
  logic                ge_found_c;
  logic                le_found_c;
  logic                gt_found_c;
  logic                lt_found_c;
  logic [FLOOR_W-1:0]  ge_floor_c;
  logic [FLOOR_W-1:0]  le_floor_c;
  logic [FLOOR_W-1:0]  gt_floor_c;
  logic [FLOOR_W-1:0]  lt_floor_c;
  int unsigned         dist_up_c;
  int unsigned         dist_dn_c;

  state_e              state_q;
  state_e              state_nxt;
  logic [FLOOR_W-1:0]  tgt_sel;
  logic [FLOOR_W-1:0]  tgt_nxt;
  logic [1:0]          dir_nxt;
  logic                valid_nxt;

  // Cabin keys are active-low; condition everything as active-high
  assign raw_lvl = {~cab_req_n_i, hall_req_i};

  for (genvar g = 0; g < N_IN; g++) begin : g_cond
`ifdef REQ_DEBOUNCE_EN
    req_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_cond (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .din   (raw_lvl[g]),
      .rise_c(set_all_c[g])
    );
`else
    req_debounce u_cond (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .din   (raw_lvl[g]),
      .rise_c(set_all_c[g])
    );
`endif
  end

  // Hall and cabin requests for one floor merge into a single bit
  assign set_c    = set_all_c[N_FLOORS-1:0] | set_all_c[N_IN-1:N_FLOORS];
  assign cur_c    = 32'(cur_floor_i);
  assign cur_ok_c = (cur_c < N_FLOORS);

  // Service clear decode; an out-of-range floor clears nothing
  always_comb begin
    clr_c = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (svc_ack_i && cur_ok_c && (i == cur_c)) begin
        clr_c[i] = 1'b1;
      end
    end
  end

  // Pending register; clear wins over a same-cycle set
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q | set_c) & ~clr_c;
    end
  end

  assign pending_o = pending_q;

  // Priority searches around the current floor
  always_comb begin
    any_c      = |pending_q;
    at_c       = 1'b0;
    ge_found_c = 1'b0;
    le_found_c = 1'b0;
    gt_found_c = 1'b0;
    lt_found_c = 1'b0;
    ge_floor_c = '0;
    le_floor_c = '0;
    gt_floor_c = '0;
    lt_floor_c = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i == cur_c) at_c = 1'b1;
        if (i >= cur_c && !ge_found_c) begin
          ge_found_c = 1'b1;
          ge_floor_c = FLOOR_W'(i);
        end
        if (i > cur_c && !gt_found_c) begin
          gt_found_c = 1'b1;
          gt_floor_c = FLOOR_W'(i);
        end
        if (i <= cur_c) begin
          le_found_c = 1'b1;
          le_floor_c = FLOOR_W'(i);
        end
        if (i < cur_c) begin
          lt_found_c = 1'b1;
          lt_floor_c = FLOOR_W'(i);
        end
      end
    end
    dist_up_c = 32'(gt_floor_c) - cur_c;
    dist_dn_c = cur_c - 32'(lt_floor_c);
  end

  // SCAN state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // SCAN next state and target selection; equal distance from idle goes down
  always_comb begin
    state_nxt = state_q;
    tgt_sel   = target_floor_o;
    if (!cur_ok_c) begin
      state_nxt = state_q;
    end else if (!any_c) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_UP: begin
          if (ge_found_c) begin
            state_nxt = ST_UP;
            tgt_sel   = ge_floor_c;
          end else begin
            state_nxt = ST_DOWN;
            tgt_sel   = le_floor_c;
          end
        end
        ST_DOWN: begin
          if (le_found_c) begin
            state_nxt = ST_DOWN;
            tgt_sel   = le_floor_c;
          end else begin
            state_nxt = ST_UP;
            tgt_sel   = ge_floor_c;
          end
        end
        default: begin
          if (at_c) begin
            state_nxt = ST_IDLE;
            tgt_sel   = cur_floor_i;
          end else if (gt_found_c && (!lt_found_c || (dist_up_c < dist_dn_c))) begin
            state_nxt = ST_UP;
            tgt_sel   = gt_floor_c;
          end else begin
            state_nxt = ST_DOWN;
            tgt_sel   = lt_floor_c;
          end
        end
      endcase
    end
  end

  // Next values of the registered target outputs
  always_comb begin
    dir_nxt   = dir_o;
    tgt_nxt   = target_floor_o;
    valid_nxt = target_valid_o;
    if (cur_ok_c) begin
      valid_nxt = any_c;
      tgt_nxt   = tgt_sel;
      case (state_nxt)
        ST_UP:   dir_nxt = DIR_UP;
        ST_DOWN: dir_nxt = DIR_DOWN;
        default: dir_nxt = DIR_IDLE;
      endcase
    end
  end

  // Target output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      dir_o          <= DIR_IDLE;
      target_floor_o <= '0;
      target_valid_o <= 1'b0;
    end else begin
      dir_o          <= dir_nxt;
      target_floor_o <= tgt_nxt;
      target_valid_o <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_request_unit.sv
// Self-checking bench for elevator_request_unit (default or REQ_DEBOUNCE_EN build).
module tb_elevator_request_unit;
  import elevator_pkg::*;

`ifdef REQ_DEBOUNCE_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] hall;
  logic [3:0] cab_n;
  logic [1:0] cur;
  logic       ack;
  logic [3:0] pend;
  logic       valid;
  logic [1:0] tgt;
  logic [1:0] dir;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         due;
    logic [3:0] pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elevator_request_unit dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .hall_req_i    (hall),
    .cab_req_n_i   (cab_n),
    .cur_floor_i   (cur),
    .svc_ack_i     (ack),
    .pending_o     (pend),
    .target_valid_o(valid),
    .target_floor_o(tgt),
    .dir_o         (dir)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void push_pend(input int lat, input logic [3:0] p);
    exp_q.push_back('{due: cyc + lat, pend: p});
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; hall = '0; cab_n = '1; cur = '0; ack = 1'b0;
    tick(2);
    n_total++; if (pend !== 4'b0000) $display("FAIL reset_pend: got %b expected 0000", pend); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
    n_total++; if (tgt !== 2'd0) $display("FAIL reset_tgt: got %0d expected 0", tgt); else n_pass++;
    n_total++; if (dir !== DIR_IDLE) $display("FAIL reset_dir: got %b expected %b", dir, DIR_IDLE); else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_up();
    cur = 2'd0; hall[3] = 1'b1;
    push_pend(LAT, 4'b1000);
    tick(LAT - 1);
    n_total++; if (pend !== 4'b0000) $display("FAIL up_early: got %b expected 0000", pend); else n_pass++;
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL up_pend: got %b expected %b", pend, e.pend); else n_pass++;
    n_total++; if (dir !== DIR_IDLE || valid !== 1'b0) $display("FAIL up_out_lag: got dir %b valid %b expected 00 0", dir, valid); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_UP || tgt !== 2'd3 || valid !== 1'b1) $display("FAIL up_target: got dir %b tgt %0d valid %b expected 01 3 1", dir, tgt, valid); else n_pass++;
    cur = 2'd3; tick();
    ack = 1'b1; push_pend(1, 4'b0000); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL up_clear: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_IDLE || valid !== 1'b0) $display("FAIL up_idle: got dir %b valid %b expected 00 0", dir, valid); else n_pass++;
    hall[3] = 1'b0;
    tick(2 * LAT + 2);
  endtask

  task automatic test_tie();
    cur = 2'd1; hall = 4'b0101;
    push_pend(LAT, 4'b0101);
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL tie_pend: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_DOWN || tgt !== 2'd0) $display("FAIL tie_down: got dir %b tgt %0d expected 10 0", dir, tgt); else n_pass++;
    cur = 2'd0; tick();
    ack = 1'b1; push_pend(1, 4'b0100); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL tie_ack0: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_UP || tgt !== 2'd2) $display("FAIL tie_reverse: got dir %b tgt %0d expected 01 2", dir, tgt); else n_pass++;
    cur = 2'd2; ack = 1'b1; push_pend(1, 4'b0000); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL tie_ack2: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_IDLE || valid !== 1'b0) $display("FAIL tie_idle: got dir %b valid %b expected 00 0", dir, valid); else n_pass++;
    hall = '0;
    tick(2 * LAT + 2);
  endtask

  task automatic test_clear_wins();
    cur = 2'd2; hall[3] = 1'b1;
    push_pend(LAT, 4'b1000);
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL cw_pend: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_UP || tgt !== 2'd3) $display("FAIL cw_up: got dir %b tgt %0d expected 01 3", dir, tgt); else n_pass++;
    cab_n[2] = 1'b0;
    tick(LAT - 1);
    ack = 1'b1; push_pend(1, 4'b1000); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL cw_clear_wins: got %b expected %b", pend, e.pend); else n_pass++;
    tick(3);
    n_total++; if (pend !== 4'b1000) $display("FAIL cw_held_key: got %b expected 1000", pend); else n_pass++;
    cab_n[2] = 1'b1;
    cur = 2'd3; ack = 1'b1; push_pend(1, 4'b0000); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL cw_cleanup: got %b expected %b", pend, e.pend); else n_pass++;
    hall[3] = 1'b0;
    tick(2 * LAT + 2);
  endtask

  task automatic test_held();
    int changes;
    cur = 2'd1; hall[3] = 1'b1;
    push_pend(LAT, 4'b1000);
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL held_pend: got %b expected %b", pend, e.pend); else n_pass++;
    changes = 0;
    repeat (200) begin
      tick();
      if (pend !== 4'b1000) changes++;
    end
    n_total++; if (changes !== 0) $display("FAIL held_200: got %0d deviating cycles expected 0", changes); else n_pass++;
    cur = 2'd3; ack = 1'b1; push_pend(1, 4'b0000); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL held_clear: got %b expected %b", pend, e.pend); else n_pass++;
    tick(2 * LAT + 5);
    n_total++; if (pend !== 4'b0000) $display("FAIL held_no_reset: got %b expected 0000", pend); else n_pass++;
    hall[3] = 1'b0;
    tick(2 * LAT);
    n_total++; if (pend !== 4'b0000) $display("FAIL held_release: got %b expected 0000", pend); else n_pass++;
    hall[3] = 1'b1;
    push_pend(LAT, 4'b1000);
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL held_repress: got %b expected %b", pend, e.pend); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0;
    hall[3] = 1'b0;
    tick(2 * LAT + 2);
  endtask

  task automatic test_merge_down();
    cur = 2'd3; hall[1] = 1'b1; hall[0] = 1'b1; cab_n[1] = 1'b0;
    push_pend(LAT, 4'b0011);
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL merge_pend: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_DOWN || tgt !== 2'd1) $display("FAIL merge_down: got dir %b tgt %0d expected 10 1", dir, tgt); else n_pass++;
    cur = 2'd1; ack = 1'b1; push_pend(1, 4'b0001); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL merge_clear: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_DOWN || tgt !== 2'd0) $display("FAIL merge_next: got dir %b tgt %0d expected 10 0", dir, tgt); else n_pass++;
    cur = 2'd0; ack = 1'b1; tick(); ack = 1'b0;
    hall = '0; cab_n = '1;
    tick(2 * LAT + 2);
  endtask

`ifdef REQ_DEBOUNCE_EN
  task automatic test_debounce();
    cur = 2'd0;
    cab_n[1] = 1'b0; tick(10); cab_n[1] = 1'b1;
    tick(40);
    n_total++; if (pend !== 4'b0000) $display("FAIL deb_glitch: got %b expected 0000", pend); else n_pass++;
    cab_n[1] = 1'b0;
    push_pend(19, 4'b0010);
    tick(18);
    n_total++; if (pend !== 4'b0000) $display("FAIL deb_early: got %b expected 0000", pend); else n_pass++;
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL deb_accept: got %b expected %b", pend, e.pend); else n_pass++;
    tick(); cab_n[1] = 1'b1;
    cur = 2'd1; ack = 1'b1; tick(); ack = 1'b0;
    tick(40);
  endtask
`else
  task automatic test_short_pulse();
    cur = 2'd0;
    hall[2] = 1'b1; push_pend(LAT, 4'b0100); tick(); hall[2] = 1'b0;
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL pulse_pend: got %b expected %b", pend, e.pend); else n_pass++;
    cur = 2'd2; ack = 1'b1; push_pend(1, 4'b0000); tick(); ack = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL pulse_clear: got %b expected %b", pend, e.pend); else n_pass++;
    tick(4);
  endtask
`endif

  task automatic test_reset_mid();
    cur = 2'd0; hall = 4'b1010;
    push_pend(LAT, 4'b1010);
    tick(exp_q[0].due - cyc); e = exp_q.pop_front();
    n_total++; if (pend !== e.pend) $display("FAIL rmid_pend: got %b expected %b", pend, e.pend); else n_pass++;
    tick();
    n_total++; if (dir !== DIR_UP || tgt !== 2'd1 || valid !== 1'b1) $display("FAIL rmid_target: got dir %b tgt %0d valid %b expected 01 1 1", dir, tgt, valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (pend !== 4'b0000) $display("FAIL rmid_pend_clr: got %b expected 0000", pend); else n_pass++;
    n_total++; if (dir !== DIR_IDLE || valid !== 1'b0 || tgt !== 2'd0) $display("FAIL rmid_outs: got dir %b valid %b tgt %0d expected 00 0 0", dir, valid, tgt); else n_pass++;
    hall = '0;
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 2);
    n_total++; if (pend !== 4'b0000) $display("FAIL rmid_after: got %b expected 0000", pend); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_tie();
    test_clear_wins();
    test_held();
    test_merge_down();
`ifdef REQ_DEBOUNCE_EN
    test_debounce();
`else
    test_short_pulse();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
